// File: rtl/pll_scan_pkg.sv
// pll_scan_pkg
//   Shared definitions for the PLL scan-chain reloader: the controller state
//   encoding and the default values for the block parameters.
package pll_scan_pkg;

    localparam int DEF_SCAN_BITS   = 144;
    localparam int DEF_ROM_LATENCY = 2;
    localparam int DEF_SCANCLK_DIV = 2;
    localparam int DEF_TIMEOUT     = 4095;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_READ        = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_WAIT_RECONF = 3'd3,
        ST_SHIFT       = 3'd4,
        ST_UPDATE      = 3'd5,
        ST_WAIT_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/pll_scanclk_gen.sv
// pll_scanclk_gen
//   Divided scan-clock generator. While en_i is high the registered level
//   sclk_o toggles every DIV system clocks, starting low. rise_o / fall_o are
//   single-cycle strobes that are high in the cycle whose closing clock edge
//   makes sclk_o go high / low, so the controller can act on that same edge.
//   Dropping en_i forces the level low and restarts the divider.
//
//   Ports
//     clock    in   system clock
//     reset_n  in   asynchronous active-low reset
//     en_i     in   run the divider
//     sclk_o   out  registered scan-clock level
//     rise_o   out  sclk_o goes 0->1 at the next clock edge
//     fall_o   out  sclk_o goes 1->0 at the next clock edge
module pll_scanclk_gen #(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    // Terminal count of the half-period divider.
    assign tc     = en_i && (cnt_q == DW'(DIV - 1));
    assign rise_o = tc && !sclk_q;
    assign fall_o = tc &&  sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/pll_scan_shifter.sv
// pll_scan_shifter
//   Reloads a PLL scan chain from an external configuration source. On start
//   it sweeps rom_address 0..SCAN_BITS-1, captures the returned bits into a
//   SCAN_BITS-wide buffer, waits for the source's rom_reconfig pulse, shifts
//   the buffer LSB-first into the PLL on a divided scan clock, strobes
//   configupdate for one scan-clock period and then waits for the PLL's
//   scandone handshake (low, then high). WAIT_RECONF and WAIT_DONE are each
//   bounded by TIMEOUT clocks; expiry sets the sticky error flag.
//
//   Ports
//     clock             in   system clock, rising edge
//     reset_n           in   asynchronous active-low reset
//     start             in   one-clock reload request (accepted only in IDLE)
//     rom_address[7:0]  out  scan-bit index presented to the source
//     rom_read_ena      out  high while the address sweep runs
//     rom_q             in   data for the address issued ROM_LATENCY clocks ago
//     rom_reconfig      in   source says "go", honoured only in WAIT_RECONF
//     busy              out  high in every state except IDLE
//     pll_scanclk       out  registered scan clock
//     pll_scanclkena    out  scan-clock enable (SHIFT only)
//     pll_scandata      out  serial scan data, changes on scanclk falls
//     pll_configupdate  out  update strobe (UPDATE only)
//     pll_scandone      in   PLL done flag, asynchronous
//     done              out  one-clock completion pulse
//     error             out  sticky timeout flag
//
//   rom_address is 8 bits wide, so SCAN_BITS above 256 would alias addresses.
//   ROM_LATENCY must be at least 1.
module pll_scan_shifter
    import pll_scan_pkg::*;
#(
    parameter int SCAN_BITS   = DEF_SCAN_BITS,
    parameter int ROM_LATENCY = DEF_ROM_LATENCY,
    parameter int SCANCLK_DIV = DEF_SCANCLK_DIV,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [7:0] rom_address,
    output logic       rom_read_ena,
    input  logic       rom_q,
    input  logic       rom_reconfig,
    output logic       busy,
    output logic       pll_scanclk,
    output logic       pll_scanclkena,
    output logic       pll_scandata,
    output logic       pll_configupdate,
    input  logic       pll_scandone,
    output logic       done,
    output logic       error
);

    localparam int CW  = $clog2(SCAN_BITS + 1);
    localparam int CYM = (TIMEOUT > ROM_LATENCY) ? TIMEOUT : ROM_LATENCY;
    localparam int CYW = $clog2(CYM + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;       // read address, then scanclk rise count
    logic [CYW-1:0]      cyc_q, cyc_d;       // drain / timeout cycle counter
    logic                err_q, err_d;
    logic                sd_q, sd_d;
    logic                seen_low_q, seen_low_d;
    logic [1:0]          sync_q;
    logic                scandone_s;
    logic [ROM_LATENCY:1] vld_pipe_q;
    logic                cap_en;
    logic                adv;
    logic [SCAN_BITS-1:0] shreg_q;
    logic                rd_ena;
    logic                gen_en, sclk, s_rise, s_fall;

    // ---------------------------------------------------------------
    // Scan clock generator: runs through SHIFT and UPDATE without a
    // break so UPDATE gets a clean full period right after the last fall.
    // ---------------------------------------------------------------
    assign gen_en = (state_q == ST_SHIFT) || (state_q == ST_UPDATE);

    pll_scanclk_gen #(
        .DIV (SCANCLK_DIV)
    ) u_sclk (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (gen_en),
        .sclk_o  (sclk),
        .rise_o  (s_rise),
        .fall_o  (s_fall)
    );

    // ---------------------------------------------------------------
    // ROM capture. The valid pipe tracks each issued address through the
    // source latency; captured bits enter at the top of the buffer so the
    // first address ends up in bit 0 after SCAN_BITS captures.
    // ---------------------------------------------------------------
    assign rd_ena = (state_q == ST_READ);
    assign cap_en = vld_pipe_q[ROM_LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_ena;
            for (int i = 2; i <= ROM_LATENCY; i++)
                vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    // Capture and shift-out never overlap in time.
    always_ff @(posedge clock) begin
        if (cap_en)
            shreg_q <= {rom_q, shreg_q[SCAN_BITS-1:1]};
        else if (adv)
            shreg_q <= {1'b0, shreg_q[SCAN_BITS-1:1]};
    end

    // ---------------------------------------------------------------
    // scandone synchronizer
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], pll_scandone};
    end
    assign scandone_s = sync_q[1];

    // ---------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        err_d      = err_q;
        sd_d       = sd_q;
        seen_low_d = seen_low_q;
        adv        = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end

            ST_READ: begin
                if (cnt_q == CW'(SCAN_BITS - 1)) begin
                    state_d = ST_DRAIN;
                    cyc_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            // Hold until the last issued address has been captured.
            ST_DRAIN: begin
                if (cyc_q == CYW'(ROM_LATENCY - 1)) begin
                    state_d = ST_WAIT_RECONF;
                    cyc_d   = '0;
                end else begin
                    cyc_d   = cyc_q + 1'b1;
                end
            end

            // Bit 0 is presented on the entry edge so it is settled well
            // before the first scanclk rise.
            ST_WAIT_RECONF: begin
                if (rom_reconfig) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sd_d    = shreg_q[0];
                    adv     = 1'b1;
                end else if (cyc_q == CYW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    sd_d    = 1'b0;
                end else begin
                    cyc_d   = cyc_q + 1'b1;
                end
            end

            // Data advances only on falls; the fall after the final rise
            // closes the phase instead, so the count stops at SCAN_BITS.
            ST_SHIFT: begin
                if (s_rise)
                    cnt_d = cnt_q + 1'b1;
                if (s_fall) begin
                    if (cnt_q == CW'(SCAN_BITS)) begin
                        state_d = ST_UPDATE;
                        sd_d    = 1'b0;
                    end else begin
                        sd_d    = shreg_q[0];
                        adv     = 1'b1;
                    end
                end
            end

            // Entered on a fall: one low half, one rise, one high half.
            ST_UPDATE: begin
                if (s_fall) begin
                    state_d    = ST_WAIT_DONE;
                    cyc_d      = '0;
                    seen_low_d = 1'b0;
                end
            end

            // A stale high scandone from the previous load must not count,
            // so a low level has to be observed first.
            ST_WAIT_DONE: begin
                if (!scandone_s)
                    seen_low_d = 1'b1;
                if (seen_low_q && scandone_s) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else if (cyc_q == CYW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    sd_d    = 1'b0;
                end else begin
                    cyc_d   = cyc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sd_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cyc_q      <= '0;
            err_q      <= 1'b0;
            sd_q       <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
            sd_q       <= sd_d;
            seen_low_q <= seen_low_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign busy             = (state_q != ST_IDLE);
    assign rom_read_ena     = rd_ena;
    assign rom_address      = rd_ena ? 8'(cnt_q) : 8'd0;
    assign pll_scanclk      = sclk;
    assign pll_scanclkena   = (state_q == ST_SHIFT);
    assign pll_configupdate = (state_q == ST_UPDATE);
    assign pll_scandata     = sd_q;
    assign error            = err_q;

endmodule

// File: tb/tb_pll_scan_shifter.sv
// Bench for pll_scan_shifter. A ROM model answers addresses after a fixed
// latency; tick() advances one clock and checks the PLL-side waveform rules
// (address sequence, data at each scanclk rise, half-period length, data
// changes only on falls, idle-low scanclk) every cycle.
module tb_pll_scan_shifter;

    localparam int N   = 144;
    localparam int L   = 2;
    localparam int DIV = 2;
    localparam int TMO = 4095;

    logic       clock = 1'b0;
    logic       reset_n, start, rom_q, rom_reconfig, pll_scandone;
    logic [7:0] rom_address;
    logic       rom_read_ena, busy, pll_scanclk, pll_scanclkena;
    logic       pll_scandata, pll_configupdate, done, error;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] pat_vec;
    int           hist[$];

    logic p_sclk = 0, p_sd = 0, p_ena = 0, p_act = 0, p_busy = 0, p_rd = 0;
    int   run_len = 0, rd_cnt = 0, rise_cnt = 0, cu_rises = 0, cu_cycles = 0;
    int   rd_falls = 0, done_cnt = 0;
    logic [7:0] sd8 = 8'h00;

    always #5 clock = ~clock;

    pll_scan_shifter #(
        .SCAN_BITS   (N),
        .ROM_LATENCY (L),
        .SCANCLK_DIV (DIV),
        .TIMEOUT     (TMO)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .rom_address      (rom_address),
        .rom_read_ena     (rom_read_ena),
        .rom_q            (rom_q),
        .rom_reconfig     (rom_reconfig),
        .busy             (busy),
        .pll_scanclk      (pll_scanclk),
        .pll_scanclkena   (pll_scanclkena),
        .pll_scandata     (pll_scandata),
        .pll_configupdate (pll_configupdate),
        .pll_scandone     (pll_scandone),
        .done             (done),
        .error            (error)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock: ROM model update plus the per-cycle waveform checks.
    task automatic tick();
        logic act;
        @(negedge clock);
        hist.push_front(rom_read_ena ? int'(rom_address) : -1);
        while (hist.size() > L + 1) void'(hist.pop_back());
        if (hist.size() > L && hist[L] >= 0) rom_q = pat_vec[hist[L]];
        else                                 rom_q = 1'($urandom_range(0, 1));

        if (busy && !p_busy) begin
            rd_cnt = 0; rise_cnt = 0; cu_rises = 0; cu_cycles = 0;
            rd_falls = 0; done_cnt = 0; sd8 = 8'h00;
        end
        if (rom_read_ena) begin
            chk("rom_address", rom_address, rd_cnt);
            rd_cnt++;
        end
        if (p_rd && !rom_read_ena) rd_falls++;

        if (pll_scanclkena && pll_scanclk && !p_sclk) begin
            chk("scandata_at_rise", pll_scandata, (rise_cnt < N) ? pat_vec[rise_cnt] : 1'b0);
            if (rise_cnt < 8) sd8[rise_cnt] = pll_scandata;
            rise_cnt++;
        end
        if (pll_configupdate) begin
            cu_cycles++;
            if (pll_scanclk && !p_sclk) cu_rises++;
        end
        if (pll_scanclkena && p_ena)
            chk("scandata_changes_only_on_fall",
                (pll_scandata != p_sd) && !(p_sclk && !pll_scanclk), 0);

        act = pll_scanclkena | pll_configupdate;
        if (act && !p_act) begin
            chk("scanclk_starts_low", pll_scanclk, 0);
            run_len = 1;
        end else if (act) begin
            if (pll_scanclk != p_sclk) begin
                chk("scanclk_half_period", run_len, DIV);
                run_len = 1;
            end else begin
                run_len++;
            end
        end else begin
            chk("scanclk_idle_low", pll_scanclk, 0);
        end
        if (done) done_cnt++;

        p_sclk = pll_scanclk; p_sd = pll_scandata; p_ena = pll_scanclkena;
        p_act = act; p_busy = busy; p_rd = rom_read_ena;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_and_reconfig();
        int n;
        n = 0;
        while (rom_read_ena && n < 400) begin tick(); n++; end
        chk("read_cycles", rd_cnt, N);
        chk("read_ena_single_window", rd_falls, 1);
        repeat (L) tick();
        chk("buffer_matches_rom", dut.shreg_q === pat_vec, 1);
        rom_reconfig = 1'b1;
        tick();
        rom_reconfig = 1'b0;
        chk("scanclkena_after_reconfig", pll_scanclkena, 1);
    endtask

    task automatic flow(input bit extra_starts);
        int n;
        pulse_start();
        chk("busy_after_start", busy, 1);
        chk("error_after_start", error, 0);
        read_and_reconfig();
        if (extra_starts) begin
            repeat (40) tick();
            repeat (3) begin pulse_start(); repeat (5) tick(); end
        end
        n = 0;
        while (!pll_configupdate && n < 1200) begin tick(); n++; end
        chk("configupdate_seen", pll_configupdate, 1);
        chk("scan_rise_count", rise_cnt, N);
        repeat (3) tick();
        pll_scandone = 1'b0;
        repeat (20) tick();
        pll_scandone = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!done && n < 8);
        chk("done_latency_2_to_3", (n >= 2 && n <= 3), 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_pulse", done_cnt, 1);
        chk("configupdate_rises", cu_rises, 1);
        chk("configupdate_cycles", cu_cycles, 2 * DIV);
        chk("error_clear_on_success", error, 0);
        chk("read_cycles_total", rd_cnt, N);
        chk("scan_rise_total", rise_cnt, N);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; rom_reconfig = 1'b0;
        rom_q = 1'b0; pll_scandone = 1'b1; pat_vec = '0;
        repeat (L + 1) hist.push_front(-1);

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_rom_read_ena", rom_read_ena, 0);
        chk("rst_rom_address", rom_address, 0);
        chk("rst_scanclk", pll_scanclk, 0);
        chk("rst_scanclkena", pll_scanclkena, 0);
        chk("rst_scandata", pll_scandata, 0);
        chk("rst_configupdate", pll_configupdate, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Run A: random pattern, start pulses during SHIFT are ignored
        for (int i = 0; i < N; i++) pat_vec[i] = 1'($urandom_range(0, 1));
        flow(1'b1);
        repeat (3) tick();

        // Run B: 0xA5 repeated; first 8 scanned bits pinned by hand
        for (int i = 0; i < N; i++) pat_vec[i] = (((8'hA5 >> (i % 8)) & 8'h01) != 0);
        flow(1'b0);
        chk("first8_scan_bits_A5", sd8, 8'hA5);
        repeat (3) tick();

        // Run C: no rom_reconfig -> timeout after DRAIN + TIMEOUT clocks
        pulse_start();
        n = 0;
        while (rom_read_ena && n < 400) begin tick(); n++; end
        n = 0;
        while (!error && n < 5000) begin tick(); n++; end
        chk("timeout_clocks", n, L + TMO);
        chk("timeout_busy", busy, 0);
        chk("timeout_scanclkena", pll_scanclkena, 0);
        chk("timeout_configupdate", pll_configupdate, 0);
        chk("timeout_scandata", pll_scandata, 0);
        repeat (5) tick();
        chk("error_sticky", error, 1);
        pulse_start();
        chk("error_cleared_by_start", error, 0);
        chk("busy_after_restart", busy, 1);

        // Run D: reset asserted at scan bit 70
        read_and_reconfig();
        n = 0;
        while (rise_cnt < 70 && n < 1000) begin tick(); n++; end
        chk("reached_bit_70", rise_cnt, 70);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rom_read_ena", rom_read_ena, 0);
        chk("abort_rom_address", rom_address, 0);
        chk("abort_scanclk", pll_scanclk, 0);
        chk("abort_scanclkena", pll_scanclkena, 0);
        chk("abort_scandata", pll_scandata, 0);
        chk("abort_configupdate", pll_configupdate, 0);
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        repeat (4) tick();
        chk("abort_no_configupdate", cu_cycles, 0);
        chk("abort_no_more_rises", rise_cnt, 70);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_abort", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
